hwpe_lic_tcdm_responder: RTL and testbench

- Target-side model of the TCDM LIC protocol used by HWPE wrapper LIC ports.
- Serves N_PORTS HWPE LIC initiators, e.g. the 2 ports of HWPE wrapper 0, from a single word-addressed memory.
- Has a round-robin arbiter, fixed one-cycle response latency and programmable grant throttling.
- Used in cluster traffic tests to stand in for the TCDM banks, so HWPE traffic can be checked in isolation.

---
 rtl/hwpe_lic_tcdm_pkg.sv | 24 ++
 rtl/hwpe_lic_tcdm_responder_if.sv | 20 ++
 rtl/lic_rr_arbiter.sv | 44 ++++
 rtl/hwpe_lic_tcdm_responder.sv | 120 ++++++++++++
 tb/tb_hwpe_lic_tcdm_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_lic_tcdm_pkg.sv
// Shared types for the TCDM LIC responder: request/response payloads and widths.
package hwpe_lic_tcdm_pkg;

  localparam int unsigned LIC_ADDR_W = 32;
  localparam int unsigned LIC_DATA_W = 32;
  localparam int unsigned LIC_BE_W   = 4;

  typedef struct packed {
    logic [LIC_ADDR_W-1:0] add;
    logic                  wen;
    logic [LIC_BE_W-1:0]   be;
    logic [LIC_DATA_W-1:0] data;
  } lic_req_t;

  typedef struct packed {
    logic [LIC_DATA_W-1:0] r_data;
    logic                  r_valid;
  } lic_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_lic_tcdm_responder_if.sv
// Multi-port TCDM LIC bundle; master = HWPE initiators, slave = responder.
interface hwpe_lic_tcdm_responder_if #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned ADDR_WIDTH = 32
);
  import hwpe_lic_tcdm_pkg::*;

  logic [N_PORTS-1:0]                 req;
  logic [N_PORTS-1:0]                 gnt;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] add;
  logic [N_PORTS-1:0]                 wen;
  logic [N_PORTS-1:0][LIC_BE_W-1:0]   be;
  logic [N_PORTS-1:0][LIC_DATA_W-1:0] data;
  logic [N_PORTS-1:0][LIC_DATA_W-1:0] r_data;
  logic [N_PORTS-1:0]                 r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/lic_rr_arbiter.sv
// Round-robin arbiter, one grant per cycle; pointer advances past the winner.
module lic_rr_arbiter #(
  parameter int unsigned N_PORTS = 2,
  localparam int unsigned IdxW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [N_PORTS-1:0] req_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     cand;
  int unsigned     nxt;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    nxt     = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      if (en_i && !valid_o && req_i[IdxW'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
    nxt = 32'(idx_o) + 1;
    if (nxt >= N_PORTS) nxt = 0;
    ptr_d = valid_o ? IdxW'(nxt) : ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hwpe_lic_tcdm_responder.sv
// TCDM stand-in: arbitrated single-word memory with 1-cycle LIC responses,
// grant throttling, out-of-range flagging and saturating access counters.
module hwpe_lic_tcdm_responder
  import hwpe_lic_tcdm_pkg::*;
#(
  parameter int unsigned           N_PORTS    = 2,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  hwpe_lic_tcdm_responder_if.slave   tcdm,
  input  logic [7:0]                 stall_cfg_i,
  output logic                       err_o,
  output logic [31:0]                rd_cnt_o,
  output logic [31:0]                wr_cnt_o
);

  localparam int unsigned IdxW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned WIdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [N_PORTS-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               acc;
  lic_req_t           sel;
  logic [LIC_ADDR_W-1:0] offset;
  logic               in_range;
  logic [WIdxW-1:0]   widx;
  logic               mem_we;
  logic               unused_addr_lsb;

  lic_rsp_t [N_PORTS-1:0] rsp_q, rsp_d;
  logic [7:0]  stall_q, stall_d;
  logic        err_q, err_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  lic_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    ((stall_q == 8'd0) && !rst_i),
    .req_i   (tcdm.req),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (acc)
  );

  assign tcdm.gnt = gnt;

  always_comb begin
    sel.add  = LIC_ADDR_W'(tcdm.add[gnt_idx]);
    sel.wen  = tcdm.wen[gnt_idx];
    sel.be   = tcdm.be[gnt_idx];
    sel.data = tcdm.data[gnt_idx];
    offset   = sel.add - LIC_ADDR_W'(BASE_ADDR);
    // Upper offset bits zero <=> offset < 4*MEM_WORDS; bits [1:0] never matter.
    in_range = (sel.add >= LIC_ADDR_W'(BASE_ADDR)) &&
               (offset[LIC_ADDR_W-1:WIdxW+2] == '0);
    widx     = offset[WIdxW+1:2];
    mem_we   = acc && !sel.wen && in_range;
  end

  assign unused_addr_lsb = ^offset[1:0];

  always_comb begin
    rsp_d = rsp_q;
    for (int unsigned p = 0; p < N_PORTS; p++) rsp_d[p].r_valid = 1'b0;
    if (acc) begin
      rsp_d[gnt_idx].r_valid = 1'b1;
      rsp_d[gnt_idx].r_data  = !sel.wen ? '0 : (in_range ? mem[widx] : ERR_RDATA);
    end
    if (acc)                  stall_d = stall_cfg_i;
    else if (stall_q != 8'd0) stall_d = stall_q - 8'd1;
    else                      stall_d = stall_q;
    err_d    = err_q | (acc & ~in_range);
    rd_cnt_d = (acc && sel.wen)  ? sat_inc(rd_cnt_q) : rd_cnt_q;
    wr_cnt_d = (acc && !sel.wen) ? sat_inc(wr_cnt_q) : wr_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(LIC_BE_W); b++) begin
        if (sel.be[b]) mem[widx][8*b +: 8] <= sel.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      tcdm.r_data[p]  = rsp_q[p].r_data;
      tcdm.r_valid[p] = rsp_q[p].r_valid;
    end
  end

  assign err_o    = err_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_hwpe_lic_tcdm_responder.sv
// Scoreboarded bench for hwpe_lic_tcdm_responder: directed LIC traffic, queued
// expected responses checked by an independent monitor for port, data and latency.
module tb_hwpe_lic_tcdm_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  stall_cfg = 8'd0;
  logic        err;
  logic [31:0] rd_cnt, wr_cnt;

  hwpe_lic_tcdm_responder_if #(.N_PORTS(2), .ADDR_WIDTH(32)) tcdm ();

  hwpe_lic_tcdm_responder #(
    .N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024),
    .BASE_ADDR(32'h1000_0000), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tcdm        (tcdm),
    .stall_cfg_i (stall_cfg),
    .err_o       (err),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void push(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    e.due  = cyc + 1;
    sb.push_back(e);
  endfunction

  // Monitor: responses must appear exactly one cycle after the grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (tcdm.r_valid != 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected actual_valid=%b required=none", tcdm.r_valid);
        end else begin
          e = sb.pop_front();
          if (tcdm.r_valid !== (2'b01 << e.port) || tcdm.r_data[e.port] !== e.data ||
              e.due != cyc) begin
            errors++;
            $display("FAIL rsp actual_valid=%b data=%h cyc=%0d required_port=%0d data=%h cyc=%0d",
                     tcdm.r_valid, tcdm.r_data[e.port], cyc, e.port, e.data, e.due);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL rsp_missing actual_valid=00 required_port=%0d", e.port);
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_rdata);
    bit got = 0;
    @(negedge clk);
    tcdm.req[p] = 1'b1; tcdm.wen[p] = w; tcdm.add[p] = a; tcdm.be[p] = b; tcdm.data[p] = d;
    for (int k = 0; k < 16 && !got; k++) begin
      #1;
      if (tcdm.gnt == (2'b01 << p)) begin
        got = 1;
        push(p, exp_rdata);
      end else begin
        if (tcdm.gnt != 2'b00) chk("gnt_wrong_port", {30'd0, tcdm.gnt}, 32'(2'b01 << p));
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout actual=none required_port=%0d", p);
    end
    @(posedge clk);
    #1 tcdm.req[p] = 1'b0;
  endtask

  initial begin
    tcdm.req = '0; tcdm.wen = '1; tcdm.add = '0; tcdm.be = '0; tcdm.data = '0;
    repeat (2) @(negedge clk);
    tcdm.req = 2'b11;
    #1;
    chk("rst_gnt_forced0", {30'd0, tcdm.gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, tcdm.r_valid}, 32'd0);
    chk("rst_rdata0", tcdm.r_data[0], 32'd0);
    chk("rst_rdata1", tcdm.r_data[1], 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_cnt", rd_cnt, 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);
    @(negedge clk);
    tcdm.req = 2'b00;
    rst = 1'b0;

    // Write then read back on port 0
    issue(0, 1'b0, BASE + 32'h10, 4'hF, 32'hCAFE_F00D, 32'h0);
    issue(0, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 32'hCAFE_F00D);
    chk("t1_wr_cnt", wr_cnt, 32'd1);
    chk("t1_rd_cnt", rd_cnt, 32'd1);
    issue(1, 1'b0, BASE + 32'h20, 4'hF, 32'h1234_5678, 32'h0);

    // Both ports reading continuously: pointer is 0 here, so 0,1,0,1
    @(negedge clk);
    tcdm.req = 2'b11; tcdm.wen = 2'b11;
    tcdm.add[0] = BASE + 32'h10; tcdm.add[1] = BASE + 32'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", {30'd0, tcdm.gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k % 2 == 0) push(0, 32'hCAFE_F00D);
      else            push(1, 32'h1234_5678);
      @(negedge clk);
    end
    tcdm.req = 2'b00;

    // Throttled back-to-back reads on port 1
    stall_cfg = 8'd3;
    tcdm.req[1] = 1'b1; tcdm.wen[1] = 1'b1; tcdm.add[1] = BASE + 32'h20;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("stall_gnt", {30'd0, tcdm.gnt}, (k % 4 == 0) ? 32'd2 : 32'd0);
      if (k % 4 == 0) push(1, 32'h1234_5678);
      @(negedge clk);
    end
    tcdm.req = 2'b00;
    stall_cfg = 8'd0;

    // Partial byte-enable write
    issue(0, 1'b0, BASE, 4'hF, 32'h0000_0000, 32'h0);
    issue(0, 1'b0, BASE, 4'b0101, 32'hFFFF_FFFF, 32'h0);
    issue(0, 1'b1, BASE, 4'hF, 32'h0, 32'h00FF_00FF);

    // Out-of-range accesses
    issue(1, 1'b0, BASE + 32'hFFC, 4'hF, 32'hA5A5_0001, 32'h0);
    chk("oor_err_before", {31'd0, err}, 32'd0);
    issue(0, 1'b1, BASE + 32'h1000, 4'hF, 32'h0, 32'hDEAD_BEEF);
    chk("oor_err_set", {31'd0, err}, 32'd1);
    issue(0, 1'b0, BASE - 32'h4, 4'hF, 32'h5555_5555, 32'h0);
    issue(1, 1'b1, BASE + 32'hFFC, 4'hF, 32'h0, 32'hA5A5_0001);
    issue(1, 1'b1, BASE, 4'hF, 32'h0, 32'h00FF_00FF);
    chk("oor_err_held", {31'd0, err}, 32'd1);
    chk("pre_rst_rd_cnt", rd_cnt, 32'd12);
    chk("pre_rst_wr_cnt", wr_cnt, 32'd6);

    // Reset right after a grant drops its response and clears state
    @(negedge clk);
    tcdm.req[0] = 1'b1; tcdm.wen[0] = 1'b1; tcdm.add[0] = BASE + 32'h10;
    #1;
    chk("mid_rst_gnt", {30'd0, tcdm.gnt}, 32'd1);
    @(posedge clk);
    rst = 1'b1;
    #1;
    tcdm.req = 2'b11; tcdm.wen = 2'b11; tcdm.add[1] = BASE + 32'h20;
    #1;
    chk("mid_rst_rvalid", {30'd0, tcdm.r_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_rd_cnt", rd_cnt, 32'd0);
    chk("mid_rst_wr_cnt", wr_cnt, 32'd0);
    chk("mid_rst_gnt_forced0", {30'd0, tcdm.gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_first_gnt", {30'd0, tcdm.gnt}, 32'd1);
    if (tcdm.gnt == 2'b01) push(0, 32'hCAFE_F00D);
    @(posedge clk);
    #1 tcdm.req = 2'b00;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
